pipelined_register_file: RTL and testbench
==========================================

# pipelined_register_file

Parametrised register file for the pipelined MIPS datapath, replacing the fixed 32×32 single-address register file. It provides N combinational read ports with same-cycle write-to-read bypass, one writeback port, and a hard-wired zero register. An integrated pending-write scoreboard lets the decode stage detect RAW hazards and block WAW issues. It sits between decode (read, issue) and writeback (write).

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- READ_PORTS, 2, number of independent read ports (≥1)
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and issues

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rd_addr  in  READ_PORTS*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  READ_PORTS*DATA_WIDTH  packed read data, combinational
- rd_busy  out  READ_PORTS  per-port: the addressed register has a pending write not satisfied this cycle
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_WIDTH  writeback destination
- wr_data  in  DATA_WIDTH  writeback value
- issue_en  in  1  decode requests to reserve a destination register
- issue_addr  in  ADDR_WIDTH  destination to reserve
- issue_stall  out  1  issue refused this cycle (WAW on a pending register)
- busy_count  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_WIDTH × DATA_WIDTH registers plus one busy bit per register.
- Read, per port, combinational:
  - ZERO_REG=1 and address 0: data 0, busy 0.
  - Otherwise, if wr_en and wr_addr equals the address: data = wr_data (bypass), busy 0.
  - Otherwise: data = stored value, busy = busy bit.
- Write: at posedge, if wr_en and not (ZERO_REG=1 and wr_addr=0), store wr_data and clear busy[wr_addr].
- A write to a non-pending register is legal: data is stored and busy stays 0.
- Issue stall: issue_stall = issue_en & busy[issue_addr] & !(wr_en & wr_addr==issue_addr). It is 0 for the zero register when ZERO_REG=1.
- Issue: at posedge, if issue_en and !issue_stall and the address is not the zero register (ZERO_REG=1), set busy[issue_addr].
- Simultaneous write and issue to the same address: the data is written and busy ends set (set wins). No stall.
- busy_count is always equal to the popcount of the busy bits. It is maintained incrementally: +1 on a new set, −1 on a clear, net 0 when both act on the same register.

## Timing
- Reset, asynchronous: all registers become 0 and all busy bits become 0. busy_count = 0; issue_stall = 0; rd_busy = 0; rd_data = 0 (or the bypass value if wr_en is active). Effect is immediate, mid-cycle.
- Reset asserted mid-operation discards all pending state. A write or issue at the same edge as reset release is ignored.
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Write latency: a value is visible through storage from the cycle after the wr_en edge, and through bypass in the same cycle.
- Busy latency: an issue accepted at edge k makes rd_busy=1 from cycle k+1 until the edge of the matching write.
- busy_count never exceeds 2**ADDR_WIDTH − ZERO_REG.

## Structure
- Package regfile_pkg: default width, depth and port constants, plus a function that extracts port i from the packed address/data buses.
- Sub-module regfile_scoreboard holds the busy bits, issue_stall logic and busy_count. Its inputs are issue_*, wr_*, reset and clk; it exposes the busy vector.
- The top level holds the storage array, bypass muxes (generate loop over READ_PORTS), and zero-register masking.

## Test plan
- Reset/zero register: assert reset → all rd_data 0, busy_count 0. Write 0xDEADBEEF to r0 → r0 still reads 0.
- Bypass: wr_en to r5 with 0x12345678, port 1 reading r5 in the same cycle → rd_data[1]=0x12345678 and rd_busy[1]=0. Next cycle, with wr_en=0 → still 0x12345678.
- RAW scoreboard: issue r7 → next cycle, reading r7 gives rd_busy=1 and busy_count=1. Write r7=0xA5 → rd_busy=0 in the same cycle, busy_count=0 after the edge.
- WAW stall: r3 pending; issue r3 again → issue_stall=1 and busy_count unchanged. Repeat the issue with a write to r3 in the same cycle → no stall, busy stays 1, busy_count stays 1.
- Fill/count: issue r1..r31 on consecutive cycles → busy_count=31. Issue r0 → no change. Write all back → busy_count=0.
- Async reset mid-flight: 4 registers pending with stored data, assert reset between clock edges → busy_count=0 and rd_data=0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and bus helpers for the pipelined register file.
// port_field() pulls one port's field out of a packed multi-port bus.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_READ_PORTS = 2;

    // Widest packed bus and widest single field port_field() can handle.
    localparam int BUS_W   = 1024;
    localparam int FIELD_W = 64;

    function automatic logic [FIELD_W-1:0] port_field(
        input logic [BUS_W-1:0] bus,
        input int               idx,
        input int               width
    );
        logic [BUS_W-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[FIELD_W-1:0];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, WAW issue stall,
// and an incrementally maintained count of pending registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic                    issue_en,
    input  logic [ADDR_WIDTH-1:0]   issue_addr,
    output logic                    issue_stall,
    output logic [2**ADDR_WIDTH-1:0] busy_vec,
    output logic [ADDR_WIDTH:0]     busy_count
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DEPTH-1:0]     busy_q, busy_d;
    logic [ADDR_WIDTH:0]  count_q, count_d;
    logic issue_zero_s, wr_same_s, stall_s, set_s, clr_s, inc_s, dec_s;

    assign issue_zero_s = ZR && (issue_addr == {ADDR_WIDTH{1'b0}});
    assign wr_same_s    = wr_en && (wr_addr == issue_addr);
    assign stall_s      = issue_en && busy_q[issue_addr] && !wr_same_s && !issue_zero_s;
    assign set_s        = issue_en && !stall_s && !issue_zero_s;
    assign clr_s        = wr_en && busy_q[wr_addr];
    // An accepted issue to an already-busy register implies a same-address
    // write clearing it, so the pair nets to zero.
    assign inc_s        = set_s && !busy_q[issue_addr];
    assign dec_s        = clr_s && !(set_s && wr_same_s);

    // Next busy vector: issue set takes priority over writeback clear.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < DEPTH; k++) begin
            busy_d[k] = (set_s && (issue_addr == ADDR_WIDTH'(k))) ||
                        (busy_q[k] && !(clr_s && (wr_addr == ADDR_WIDTH'(k))));
        end
    end

    // Next pending count from the set/clear events of this cycle.
    always_comb begin
        count_d = count_q;
        case ({inc_s, dec_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= {DEPTH{1'b0}};
            count_q <= {(ADDR_WIDTH+1){1'b0}};
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign issue_stall = stall_s;
    assign busy_vec    = busy_q;
    assign busy_count  = count_q;

endmodule

// File: rtl/pipelined_register_file.sv
// Multi-port register file with write-to-read bypass, optional hard-wired
// zero register and an integrated pending-write scoreboard.
module pipelined_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int READ_PORTS = DEF_READ_PORTS,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [READ_PORTS-1:0]            rd_busy,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             issue_en,
    input  logic [ADDR_WIDTH-1:0]            issue_addr,
    output logic                             issue_stall,
    output logic [ADDR_WIDTH:0]              busy_count
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      busy_s;
    logic                  wr_store_s;
    logic [BUS_W-1:0]      rd_addr_ext_s;

    assign wr_store_s    = wr_en && !(ZR && (wr_addr == {ADDR_WIDTH{1'b0}}));
    assign rd_addr_ext_s = BUS_W'(rd_addr);

    // Register storage; writes to the zero register are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {DATA_WIDTH{1'b0}};
            end
        end else if (wr_store_s) begin
            mem_q[wr_addr] <= wr_data;
        end else begin
            mem_q[wr_addr] <= mem_q[wr_addr];
        end
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_stall (issue_stall),
        .busy_vec    (busy_s),
        .busy_count  (busy_count)
    );

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr_s;
        logic [DATA_WIDTH-1:0] data_s;
        logic                  busy_p_s;

        assign addr_s = ADDR_WIDTH'(port_field(rd_addr_ext_s, p, ADDR_WIDTH));

        // Read mux: zero register, then same-cycle bypass, then storage.
        always_comb begin
            data_s   = mem_q[addr_s];
            busy_p_s = busy_s[addr_s];
            if (ZR && (addr_s == {ADDR_WIDTH{1'b0}})) begin
                data_s   = {DATA_WIDTH{1'b0}};
                busy_p_s = 1'b0;
            end else if (wr_en && (wr_addr == addr_s)) begin
                data_s   = wr_data;
                busy_p_s = 1'b0;
            end else begin
                data_s   = mem_q[addr_s];
                busy_p_s = busy_s[addr_s];
            end
        end

        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data_s;
        assign rd_busy[p]                          = busy_p_s;
    end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Randomized and directed self-checking bench for pipelined_register_file,
// compared against an array-based reference model of the register file.
module tb_pipelined_register_file;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int RP    = 2;
    localparam int DEPTH = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [RP*AW-1:0]   rd_addr = '0;
    logic [RP*DW-1:0]   rd_data;
    logic [RP-1:0]      rd_busy;
    logic               wr_en = 1'b0;
    logic [AW-1:0]      wr_addr = '0;
    logic [DW-1:0]      wr_data = '0;
    logic               issue_en = 1'b0;
    logic [AW-1:0]      issue_addr = '0;
    logic               issue_stall;
    logic [AW:0]        busy_count;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_busy [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    pipelined_register_file #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 5'd0) return 32'd0;
        if (wr_en && wr_addr == a) return wr_data;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 5'd0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return ref_busy[a];
    endfunction

    function automatic logic exp_stall();
        return issue_en && (issue_addr != 5'd0) && ref_busy[issue_addr] &&
               !(wr_en && wr_addr == issue_addr);
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int k = 0; k < DEPTH; k++) c += ref_busy[k] ? 1 : 0;
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin ref_mem[k] = '0; ref_busy[k] = 0; end
    endtask

    task automatic model_edge();
        logic st;
        if (reset) begin
            model_clear();
        end else begin
            st = exp_stall();
            if (wr_en && wr_addr != 5'd0) begin
                ref_mem[wr_addr] = wr_data;
                ref_busy[wr_addr] = 0;
            end
            if (issue_en && !st && issue_addr != 5'd0) ref_busy[issue_addr] = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); set_rd(5'd0, 5'd9);
        tick();
        n_checks++; if (busy_count !== 6'd0) begin n_errors++; $display("FAIL reset_count got=%0d exp=0", busy_count); end
        n_checks++; if (rd_data !== 64'd0) begin n_errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        n_checks++; if (rd_busy !== 2'b00 || issue_stall !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b/%b exp=00/0", rd_busy, issue_stall); end
        reset = 1'b0;
        #1;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; set_rd(5'd0, 5'd0);
        #1;
        n_checks++; if (rd_data[31:0] !== 32'd0) begin n_errors++; $display("FAIL zero_bypass got=%h exp=0", rd_data[31:0]); end
        tick(); idle(); #1;
        n_checks++; if (rd_data[63:32] !== 32'd0) begin n_errors++; $display("FAIL zero_store got=%h exp=0", rd_data[63:32]); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; set_rd(5'd0, 5'd5);
        #1;
        n_checks++; if (rd_data[63:32] !== 32'h12345678) begin n_errors++; $display("FAIL bypass_data got=%h exp=12345678", rd_data[63:32]); end
        n_checks++; if (rd_busy[1] !== 1'b0) begin n_errors++; $display("FAIL bypass_busy got=%b exp=0", rd_busy[1]); end
        tick(); idle(); #1;
        n_checks++; if (rd_data[63:32] !== 32'h12345678) begin n_errors++; $display("FAIL bypass_stored got=%h exp=12345678", rd_data[63:32]); end
    endtask

    task automatic test_raw();
        issue_en = 1'b1; issue_addr = 5'd7;
        tick(); idle(); set_rd(5'd7, 5'd0); #1;
        n_checks++; if (rd_busy[0] !== 1'b1) begin n_errors++; $display("FAIL raw_busy got=%b exp=1", rd_busy[0]); end
        n_checks++; if (busy_count !== 6'd1) begin n_errors++; $display("FAIL raw_count got=%0d exp=1", busy_count); end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h000000A5; #1;
        n_checks++; if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5) begin n_errors++; $display("FAIL raw_wb got=%b/%h exp=0/a5", rd_busy[0], rd_data[31:0]); end
        tick(); idle(); #1;
        n_checks++; if (busy_count !== 6'd0) begin n_errors++; $display("FAIL raw_count_clr got=%0d exp=0", busy_count); end
    endtask

    task automatic test_waw();
        issue_en = 1'b1; issue_addr = 5'd3;
        tick(); #1;
        n_checks++; if (issue_stall !== 1'b1) begin n_errors++; $display("FAIL waw_stall got=%b exp=1", issue_stall); end
        tick(); idle(); #1;
        n_checks++; if (busy_count !== 6'd1) begin n_errors++; $display("FAIL waw_count got=%0d exp=1", busy_count); end
        issue_en = 1'b1; issue_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; set_rd(5'd3, 5'd3); #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_errors++; $display("FAIL waw_wr_nostall got=%b exp=0", issue_stall); end
        tick(); idle(); #1;
        n_checks++; if (rd_busy[0] !== 1'b1 || busy_count !== 6'd1 || rd_data[31:0] !== 32'h33) begin
            n_errors++; $display("FAIL waw_setwins got=%b/%0d/%h exp=1/1/33", rd_busy[0], busy_count, rd_data[31:0]); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h333;
        tick(); idle();
    endtask

    task automatic test_fill();
        for (int i = 1; i < DEPTH; i++) begin
            issue_en = 1'b1; issue_addr = 5'(i); tick();
        end
        idle(); #1;
        n_checks++; if (busy_count !== 6'd31) begin n_errors++; $display("FAIL fill_count got=%0d exp=31", busy_count); end
        issue_en = 1'b1; issue_addr = 5'd0; #1;
        n_checks++; if (issue_stall !== 1'b0) begin n_errors++; $display("FAIL fill_r0_stall got=%b exp=0", issue_stall); end
        tick(); issue_addr = 5'd17; #1;
        n_checks++; if (busy_count !== 6'd31 || issue_stall !== 1'b1) begin n_errors++; $display("FAIL fill_full got=%0d/%b exp=31/1", busy_count, issue_stall); end
        idle();
        for (int i = 1; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = $urandom; tick();
        end
        idle(); #1;
        n_checks++; if (busy_count !== 6'd0) begin n_errors++; $display("FAIL drain_count got=%0d exp=0", busy_count); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 400; n++) begin
            rd_addr  = RP*AW'($urandom);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            issue_en = 1'($urandom_range(0, 1));
            issue_addr = (n % 3 == 0) ? wr_addr : 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < RP; p++) begin
                a = rd_addr[p*AW +: AW];
                n_checks++; if (rd_data[p*DW +: DW] !== exp_data(a)) begin
                    n_errors++; $display("FAIL rand_data p%0d r%0d got=%h exp=%h", p, a, rd_data[p*DW +: DW], exp_data(a)); end
                n_checks++; if (rd_busy[p] !== exp_busy(a)) begin
                    n_errors++; $display("FAIL rand_busy p%0d r%0d got=%b exp=%b", p, a, rd_busy[p], exp_busy(a)); end
            end
            n_checks++; if (issue_stall !== exp_stall()) begin n_errors++; $display("FAIL rand_stall got=%b exp=%b", issue_stall, exp_stall()); end
            n_checks++; if (busy_count !== 6'(exp_count()) || busy_count > 6'd31) begin
                n_errors++; $display("FAIL rand_count got=%0d exp=%0d", busy_count, exp_count()); end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int r = 10; r < 14; r++) begin
            wr_en = 1'b1; wr_addr = 5'(r); wr_data = $urandom | 32'h1; tick();
        end
        idle();
        for (int r = 10; r < 14; r++) begin
            issue_en = 1'b1; issue_addr = 5'(r); tick();
        end
        idle(); set_rd(5'd10, 5'd11); #1;
        n_checks++; if (busy_count !== 6'(exp_count())) begin n_errors++; $display("FAIL pre_reset_count got=%0d exp=%0d", busy_count, exp_count()); end
        #2 reset = 1'b1; model_clear(); #1;
        n_checks++; if (busy_count !== 6'd0 || rd_data !== 64'd0 || rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL async_reset got=%0d/%h/%b exp=0/0/00", busy_count, rd_data, rd_busy); end
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hFFFF; issue_en = 1'b1; issue_addr = 5'd12; #1;
        n_checks++; if (rd_data[31:0] !== 32'hFFFF) begin n_errors++; $display("FAIL reset_bypass got=%h exp=ffff", rd_data[31:0]); end
        tick(); idle(); #2 reset = 1'b0; set_rd(5'd10, 5'd12); #1;
        n_checks++; if (rd_data !== 64'd0 || busy_count !== 6'd0 || rd_busy !== 2'b00) begin
            n_errors++; $display("FAIL reset_edge_ignored got=%h/%0d/%b exp=0/0/00", rd_data, busy_count, rd_busy); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_bypass();
        test_raw();
        test_waw();
        test_fill();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
